// File: rtl/przebieg_pkg.sv
// Shared constants and types for the LED waveform checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package przebieg_pkg;

  localparam int PAT_LEN = 12;
  localparam int PHASE_W = 4;
  localparam logic [PAT_LEN-1:0] DEF_PATTERN = 12'b110011101000;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/przebieg_sampler.sv
// Synchronizes the async LED line, detects edges and produces one mid-bit sample tick per step.
// Latency: 2 cycles to s, edge seen 1 cycle later; tick BIT_PERIOD/2 cycles after a detected edge.
// Backpressure: none; free-running.
// Ports: clk/rst_n (async active-low), led (async input), tick (1-cycle strobe), sample (value at tick).
module przebieg_sampler #(
  parameter int BIT_PERIOD = 2000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic led,
  output logic tick,
  output logic sample
);

  localparam int TW = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [TW-1:0] T_MID  = TW'(BIT_PERIOD / 2 - 1);

  logic          sync1_q, sync1_d;
  logic          s_q, s_d;
  logic          s_dly_q, s_dly_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          edge_det;

  always_comb begin
    sync1_d  = led;
    s_d      = sync1_q;
    s_dly_d  = s_q;
    edge_det = s_q ^ s_dly_q;
    if (edge_det || timer_q == T_LAST) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    // An edge coinciding with the mid-point restarts the bit; no sample then.
    tick   = (timer_q == T_MID) && !edge_det;
    sample = s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
      timer_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      s_q     <= s_d;
      s_dly_q <= s_dly_d;
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/przebieg_check.sv
// Aligns to the 12-step LED pattern, flags mismatched steps and counts them (saturating at 255).
// Latency: all outputs registered, updating the cycle after each sample tick.
// Backpressure: none; observe-only checker.
// Ports: iCLK/iRST_N (async active-low), iLED (async), oLOCK, oERR (1-cycle pulse),
//        oPHASE (next expected step, 0 when unlocked), oERRCNT (saturating mismatch count).
module przebieg_check
  import przebieg_pkg::*;
#(
  parameter int                 BIT_PERIOD = 2000000,
  parameter logic [PAT_LEN-1:0] PATTERN    = DEF_PATTERN,
  parameter int                 LOCK_MISS  = 2
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iLED,
  output logic               oLOCK,
  output logic               oERR,
  output logic [PHASE_W-1:0] oPHASE,
  output logic [7:0]         oERRCNT
);

  logic tick;
  logic sample;

  przebieg_sampler #(.BIT_PERIOD(BIT_PERIOD)) u_sampler (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .led    (iLED),
    .tick   (tick),
    .sample (sample)
  );

  state_e               state_q, state_d;
  logic [PAT_LEN-1:0]   hist_q, hist_d, hist_new;
  logic [3:0]           fill_q, fill_d, fill_new;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [2:0]           miss_q, miss_d, miss_inc;
  logic [7:0]           errcnt_q, errcnt_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    phase_d  = phase_q;
    miss_d   = miss_q;
    errcnt_d = errcnt_q;
    err_d    = 1'b0;

    // Oldest sample ends up in bit 0, so a stream starting at step 0 lands as hist == PATTERN.
    hist_new = {sample, hist_q[PAT_LEN-1:1]};
    fill_new = (fill_q == 4'(PAT_LEN)) ? fill_q : fill_q + 4'd1;
    miss_inc = miss_q + 3'd1;

    if (tick) begin
      hist_d = hist_new;
      fill_d = fill_new;
      if (state_q == SEARCH) begin
        // Rotations of PATTERN are all distinct, so a full-window match pins phase 0.
        if (fill_new == 4'(PAT_LEN) && hist_new == PATTERN) begin
          state_d = LOCKED;
          phase_d = '0;
          miss_d  = '0;
        end
      end else begin
        phase_d = (phase_q == PHASE_W'(PAT_LEN - 1)) ? '0 : phase_q + PHASE_W'(1);
        if (sample == PATTERN[phase_q]) begin
          miss_d = '0;
        end else begin
          err_d  = 1'b1;
          miss_d = miss_inc;
          if (errcnt_q != 8'hFF) begin
            errcnt_d = errcnt_q + 8'd1;
          end
          // Too many consecutive misses: restart acquisition with a fresh window.
          if (miss_inc == 3'(LOCK_MISS)) begin
            state_d = SEARCH;
            fill_d  = '0;
            miss_d  = '0;
            phase_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= SEARCH;
      hist_q   <= '0;
      fill_q   <= '0;
      phase_q  <= '0;
      miss_q   <= '0;
      errcnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      phase_q  <= phase_d;
      miss_q   <= miss_d;
      errcnt_q <= errcnt_d;
      err_q    <= err_d;
    end
  end

  // phase is held at 0 outside LOCKED, so it can drive oPHASE directly.
  assign oLOCK   = (state_q == LOCKED);
  assign oERR    = err_q;
  assign oPHASE  = phase_q;
  assign oERRCNT = errcnt_q;

endmodule

// File: tb/tb_przebieg_check.sv
// Directed bench for przebieg_check with BIT_PERIOD = 8.
// Latency: steps are driven 8 cycles apart, aligned so each tick lands mid-step.
// Backpressure: n/a.
module tb_przebieg_check;

  localparam logic [11:0] PAT = 12'b110011101000;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       iLED = 1'b0;
  logic       oLOCK;
  logic       oERR;
  logic [3:0] oPHASE;
  logic [7:0] oERRCNT;

  int total = 0;
  int bad   = 0;
  int g     = 0;   // stream position of the next step to drive

  przebieg_check #(.BIT_PERIOD(8)) dut (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .iLED    (iLED),
    .oLOCK   (oLOCK),
    .oERR    (oERR),
    .oPHASE  (oPHASE),
    .oERRCNT (oERRCNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s step=%0d got=%0d exp=%0d", tag, g, got, exp);
    end
  endtask

  // Drive one step (optionally inverted) for n cycles, then check the outputs
  // produced by that step's tick and how many cycles oERR was high.
  task automatic drive(input logic inv, input int n, input int el, input int ep,
                       input int ee, input int ec);
    int idx;
    int errs;
    idx  = g % 12;
    errs = 0;
    iLED = PAT[idx] ^ inv;
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK);
      #1;
      if (oERR) errs++;
    end
    chk("lock", 32'(oLOCK), el);
    chk("phase", 32'(oPHASE), ep);
    chk("err_cycles", errs, ee);
    chk("errcnt", 32'(oERRCNT), ec);
    g++;
  endtask

  // Hold reset with the first step's level on iLED, then release between edges.
  // Returns the first step's window: with a low level the free-running timer is
  // already in phase (5 cycles to the next boundary); a high level makes the
  // synchronizer see a power-up edge that restarts the timer (8 cycles).
  task automatic restart(input int start, output int n0);
    iRST_N = 1'b0;
    g      = start;
    iLED   = PAT[start];
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    n0     = PAT[start] ? 8 : 5;
  endtask

  initial begin
    int n0;

    // Reset held: toggling iLED must not disturb any output.
    for (int i = 0; i < 6; i++) begin
      iLED = ~iLED;
      repeat (3) @(posedge iCLK);
      #1;
      chk("rst_lock", 32'(oLOCK), 0);
      chk("rst_err", 32'(oERR), 0);
      chk("rst_phase", 32'(oPHASE), 0);
      chk("rst_errcnt", 32'(oERRCNT), 0);
    end

    // Stream from step 0: lock right after the 12th tick, then phase cycles.
    restart(0, n0);
    for (int k = 0; k < 36; k++) begin
      drive(1'b0, (k == 0) ? n0 : 8, (k >= 11) ? 1 : 0,
            (k >= 11) ? (k + 1) % 12 : 0, 0, 0);
    end

    // Single inverted step 3: one pulse, lock kept, no phase slip.
    for (int k = 0; k < 12; k++) begin
      drive(k == 3, 8, 1, (k + 1) % 12, (k == 3) ? 1 : 0, (k >= 3) ? 1 : 0);
    end

    // Steps 6 and 7 inverted: second miss drops lock in the same update.
    for (int k = 0; k < 12; k++) begin
      if (k < 6)       drive(1'b0, 8, 1, k + 1, 0, 1);
      else if (k == 6) drive(1'b1, 8, 1, 7, 1, 2);
      else if (k == 7) drive(1'b1, 8, 0, 0, 1, 3);
      else             drive(1'b0, 8, 0, 0, 0, 3);
    end
    // Re-lock only once steps 0..11 have all been seen again.
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 8, (k == 11) ? 1 : 0, 0, 0, 3);
    end

    // Fresh reset, stream from step 5: lock after tick 19 (worst case is 23).
    restart(5, n0);
    for (int t = 1; t <= 19; t++) begin
      drive(1'b0, (t == 1) ? n0 : 8, (t == 19) ? 1 : 0, 0, 0, 0);
    end

    // 300 isolated mismatches (every other step) keep lock; count saturates.
    for (int j = 0; j < 600; j++) begin
      drive(j % 2 == 0, 8, 1, (j + 1) % 12, (j % 2 == 0) ? 1 : 0,
            (j / 2 + 1 > 255) ? 255 : j / 2 + 1);
    end

    // Mid-bit reset: outputs clear without waiting for a clock edge.
    iLED = PAT[g % 12];
    repeat (3) @(posedge iCLK);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("arst_lock", 32'(oLOCK), 0);
    chk("arst_phase", 32'(oPHASE), 0);
    chk("arst_errcnt", 32'(oERRCNT), 0);
    chk("arst_err", 32'(oERR), 0);
    #20;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
